// File: rtl/dmem_dma_arbiter.sv
// rtl/dmem_dma_arbiter.sv - data_memory port arbiter between the CPU MEM stage and a DMA burst engine
// CPU wins collisions; a starvation counter forces one DMA beat after STARVE_LIMIT lost cycles.
module dmem_dma_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LEN_W        = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read_en,
    input  logic              cpu_write_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_start,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_base,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [31:0]       dma_wdata,
    output logic              dma_wready,
    output logic [31:0]       dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_busy,
    output logic              dma_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [3:0]        starve_q, starve_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic cpu_access;
    logic grant_dma;

    assign cpu_access = cpu_read_en | cpu_write_en;
    assign grant_dma  = (state_q == S_BUSY) && (!cpu_access || (starve_q == STARVE_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            starve_q <= 4'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                starve_d = 4'd0;
                if (dma_start) begin
                    we_d    = dma_we;
                    addr_d  = {dma_base[ADDR_W-1:2], 2'b00};
                    len_d   = dma_len;
                    beat_d  = '0;
                    state_d = (dma_len == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (grant_dma) begin
                    starve_d = 4'd0;
                    addr_d   = addr_q + ADDR_W'(4);
                    beat_d   = beat_q + LEN_W'(1);
                    if (!we_q) begin
                        rdata_d  = mem_rdata;
                        rvalid_d = 1'b1;
                    end
                    if (beat_q + LEN_W'(1) == len_q) begin
                        state_d = S_DONE;
                    end
                end else if (cpu_access && (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Zero-latency mux: a granted DMA beat replaces the CPU request, which stalls and retries.
    always_comb begin
        if (grant_dma) begin
            mem_addr     = addr_q;
            mem_wdata    = dma_wdata;
            mem_write_en = we_q;
            mem_read_en  = !we_q;
        end else begin
            mem_addr     = cpu_addr;
            mem_wdata    = cpu_wdata;
            mem_write_en = cpu_write_en;
            mem_read_en  = cpu_read_en;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = grant_dma & cpu_access;
    assign dma_wready = grant_dma & we_q;
    assign dma_rdata  = rdata_q;
    assign dma_rvalid = rvalid_q;
    assign dma_busy   = (state_q == S_BUSY);
    assign dma_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// tb/tb_dmem_dma_arbiter.sv - randomized scoreboard bench for dmem_dma_arbiter
module tb_dmem_dma_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_read_en = 1'b0, cpu_write_en = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_start = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_base = 32'd0;
    logic [7:0]  dma_len = 8'd0;
    logic [31:0] dma_wdata;
    logic        dma_wready;
    logic [31:0] dma_rdata;
    logic        dma_rvalid, dma_busy, dma_done;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_write_en, mem_read_en;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_dma_arbiter #(.ADDR_W(32), .LEN_W(8), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_wready(dma_wready),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .dma_busy(dma_busy), .dma_done(dma_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 32) return 32'h11;
        if (i == 33) return 32'h22;
        return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    endfunction

    // Data memory model: 4 KB aliased window, combinational read, write at the clock edge.
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_write_en) mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    // DMA write source: presents word (taken - base) and moves on after each consumed word.
    logic [31:0] src_buf [0:255];
    int wr_taken = 0;
    int src_base = 0;
    assign dma_wdata = src_buf[8'(wr_taken - src_base)];
    always @(posedge clk) if (dma_wready) wr_taken <= wr_taken + 1;

    logic [31:0] exp_wr_a[$];
    logic [31:0] exp_wr_d[$];
    logic [31:0] exp_rd[$];
    int wr_ptr = 0, rd_ptr = 0;

    int busy_cnt = 0, stall_cnt = 0, done_cnt = 0, wready_cnt = 0;

    // Reference: remaining beats of the accepted burst and CPU wins since the last beat.
    int m_pend = 0;
    int m_won = 0;
    bit m_we = 1'b0, m_done_now = 1'b0, m_rv_now = 1'b0;
    bit cpu_acc, exp_busy, exp_beat, nxt_done, nxt_rv;

    always @(negedge clk) begin
        if (!reset) begin
            m_pend = 0; m_won = 0; m_done_now = 0; m_rv_now = 0;
            wr_ptr = exp_wr_a.size();
            rd_ptr = exp_rd.size();
        end else begin
            cpu_acc  = cpu_read_en | cpu_write_en;
            exp_busy = (m_pend != 0);
            exp_beat = exp_busy && (!cpu_acc || m_won == STARVE);
            chk1("busy", dma_busy, exp_busy);
            chk1("done", dma_done, m_done_now);
            chk1("stall", cpu_stall, exp_beat && cpu_acc);
            chk1("wready", dma_wready, exp_beat && m_we);
            chk1("rvalid", dma_rvalid, m_rv_now);
            chk1("mem_we", mem_write_en, exp_beat ? m_we : cpu_write_en);
            chk1("mem_re", mem_read_en, exp_beat ? !m_we : cpu_read_en);
            if (mem_write_en) begin
                if (wr_ptr < exp_wr_a.size()) begin
                    chk("wr_addr", mem_addr, exp_wr_a[wr_ptr]);
                    chk("wr_data", mem_wdata, exp_wr_d[wr_ptr]);
                    wr_ptr++;
                end else begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: addr %h data %h with none expected", mem_addr, mem_wdata);
                end
            end
            if (dma_rvalid) begin
                if (rd_ptr < exp_rd.size()) begin
                    chk("rd_data", dma_rdata, exp_rd[rd_ptr]);
                    rd_ptr++;
                end else begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rvalid: data %h with none expected", dma_rdata);
                end
            end
            if (cpu_read_en && !exp_beat) begin
                chk("cpu_addr_pass", mem_addr, cpu_addr);
                chk("cpu_rdata", cpu_rdata, mem[cpu_addr[11:2]]);
            end
            if (dma_busy) busy_cnt++;
            if (cpu_stall) stall_cnt++;
            if (dma_done) done_cnt++;
            if (dma_wready) wready_cnt++;

            nxt_done = exp_beat && (m_pend == 1);
            nxt_rv   = exp_beat && !m_we;
            if (exp_beat) begin
                m_pend--;
                m_won = 0;
            end else if (exp_busy && cpu_acc) begin
                m_won++;
            end
            if (!exp_busy) m_won = 0;
            if (dma_start && !exp_busy && !m_done_now) begin
                m_we = dma_we;
                if (dma_len == 8'd0) nxt_done = 1'b1;
                else m_pend = int'(dma_len);
            end
            m_done_now = nxt_done;
            m_rv_now   = nxt_rv;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input bit we, input logic [31:0] base, input int len);
        logic [31:0] a;
        src_base = wr_taken;
        for (int i = 0; i < len; i++) begin
            a = {base[31:2], 2'b00} + 32'(4 * i);
            if (we) begin
                exp_wr_a.push_back(a);
                exp_wr_d.push_back(src_buf[i]);
                ref_mem[a[11:2]] = src_buf[i];
            end else begin
                exp_rd.push_back(ref_mem[a[11:2]]);
            end
        end
        dma_start = 1'b1; dma_we = we; dma_base = base; dma_len = 8'(len);
        cyc();
        dma_start = 1'b0;
        dma_we = 1'($urandom); dma_base = $urandom; dma_len = 8'($urandom);
    endtask

    task automatic wait_done(input int d0, input int pct, input int budget);
        int r;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            cpu_read_en = ($urandom_range(0, 99) < pct);
            r = $urandom_range(0, 1023);
            cpu_addr = 32'(r) << 2;
            cyc();
        end
        chk1("done_seen", done_cnt != d0, 1'b1);
        cpu_read_en = 1'b0;
    endtask

    task automatic fill_src(input int len);
        for (int i = 0; i < len; i++) src_buf[i] = $urandom;
    endtask

    int b0, s0, d0, w0, len, pct;
    logic [31:0] saved [0:7];

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 256; i++) src_buf[i] = 32'd0;

        cpu_read_en = 1'b1; cpu_addr = 32'h1234;
        repeat (3) cyc();
        chk1("rst_busy", dma_busy, 1'b0);
        chk1("rst_done", dma_done, 1'b0);
        chk1("rst_rvalid", dma_rvalid, 1'b0);
        chk("rst_rdata", dma_rdata, 32'd0);
        chk1("rst_stall", cpu_stall, 1'b0);
        chk1("rst_wready", dma_wready, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h1234);
        chk1("rst_mem_re", mem_read_en, 1'b1);
        cpu_read_en = 1'b0;
        reset = 1'b1;
        cyc();

        // Write burst, CPU idle
        src_buf[0] = 32'hAAAA0001; src_buf[1] = 32'hBBBB0002;
        src_buf[2] = 32'hCCCC0003; src_buf[3] = 32'hDDDD0004;
        b0 = busy_cnt; s0 = stall_cnt; d0 = done_cnt; w0 = wready_cnt;
        start_burst(1'b1, 32'h40, 4);
        wait_done(d0, 0, 20);
        chk("t1_busy_cycles", busy_cnt - b0, 4);
        chk("t1_wready_cycles", wready_cnt - w0, 4);
        chk("t1_stalls", stall_cnt - s0, 0);

        // Read burst of preloaded words
        d0 = done_cnt; b0 = busy_cnt;
        start_burst(1'b0, 32'h80, 2);
        wait_done(d0, 0, 20);
        chk("t2_busy_cycles", busy_cnt - b0, 2);

        // Starvation: CPU reads every cycle
        fill_src(2);
        cpu_read_en = 1'b1; cpu_addr = 32'h40;
        b0 = busy_cnt; s0 = stall_cnt; d0 = done_cnt;
        start_burst(1'b1, 32'h60, 2);
        wait_done(d0, 100, 40);
        chk("t3_busy_cycles", busy_cnt - b0, 2 * (STARVE + 1));
        chk("t3_stalls", stall_cnt - s0, 2);

        // Zero-length burst
        b0 = busy_cnt; d0 = done_cnt;
        start_burst(1'b1, 32'h90, 0);
        wait_done(d0, 0, 5);
        chk("t4_busy_cycles", busy_cnt - b0, 0);
        chk("t4_done_cycles", done_cnt - d0, 1);

        // Reset after three beats of an 8-word burst
        fill_src(8);
        for (int i = 0; i < 8; i++) saved[i] = ref_mem[16'h40 + i];
        w0 = wready_cnt;
        start_burst(1'b1, 32'h100, 8);
        for (int i = 0; i < 40 && wready_cnt < w0 + 3; i++) cyc();
        chk("t5_beats_before_reset", wready_cnt - w0, 3);
        reset = 1'b0;
        #1;
        chk1("t5_busy_clr", dma_busy, 1'b0);
        chk1("t5_wready_clr", dma_wready, 1'b0);
        chk1("t5_mem_we_clr", mem_write_en, 1'b0);
        cyc();
        reset = 1'b1;
        for (int i = 3; i < 8; i++) ref_mem[16'h40 + i] = saved[i];
        chk("t5_word2_written", mem[16'h42], src_buf[2]);
        chk("t5_word3_untouched", mem[16'h43], saved[3]);
        fill_src(3);
        d0 = done_cnt;
        start_burst(1'b1, 32'h180, 3);
        wait_done(d0, 30, 40);

        // Start while busy is ignored; address wrap
        fill_src(4);
        d0 = done_cnt;
        start_burst(1'b1, 32'h300, 4);
        dma_start = 1'b1; dma_we = 1'b0; dma_base = 32'h200; dma_len = 8'd3;
        cyc();
        dma_start = 1'b0;
        wait_done(d0, 0, 20);
        fill_src(2);
        d0 = done_cnt;
        start_burst(1'b1, 32'hFFFFFFFC, 2);
        wait_done(d0, 0, 20);
        d0 = done_cnt;
        start_burst(1'b0, 32'hFFFFFFFC, 2);
        wait_done(d0, 0, 20);

        // Randomized bursts under random CPU load
        for (int n = 0; n < 16; n++) begin
            len = $urandom_range(1, 12);
            pct = $urandom_range(0, 100);
            fill_src(len);
            d0 = done_cnt;
            start_burst(1'($urandom), 32'($urandom_range(0, 4095)), len);
            wait_done(d0, pct, len * (STARVE + 1) + 10);
            repeat ($urandom_range(0, 2)) cyc();
        end

        cyc();
        chk("all_writes_seen", wr_ptr, exp_wr_a.size());
        chk("all_reads_seen", rd_ptr, exp_rd.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

endmodule
